// File: rtl/mem_req_arbiter_if.sv
// sram-like request/response bundle shared by the inst, data and memory sides of mem_req_arbiter.
// master drives the request payload; slave answers with addr_ok/data_ok/rdata.
interface mem_req_arbiter_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, addr, wstrb, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wstrb, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/mem_req_arbiter.sv
// Shares one sram-like memory port between the inst and data requesters, routing responses in order.
// Define RR_ARB_EN for round-robin arbitration; otherwise data_req has fixed priority over inst_req.
module mem_req_arbiter #(
  parameter int OUTSTANDING = 2,
  parameter int OWN_W       = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  mem_req_arbiter_if.slave      inst_bus,
  mem_req_arbiter_if.slave      data_bus,
  mem_req_arbiter_if.master     mem_bus,
  output logic                  resp_err
);

  localparam int CNT_W = $clog2(OUTSTANDING) + 1;
  localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(OUTSTANDING);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(OUTSTANDING - 1);
  localparam logic [OWN_W-1:0] OWN_INST = '0;
  localparam logic [OWN_W-1:0] OWN_DATA = OWN_W'(1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t             state_q, state_d;
  logic [OWN_W-1:0]   grant_q, grant_d;
  logic [OWN_W-1:0]   own_q [OUTSTANDING];
  logic [OWN_W-1:0]   own_d [OUTSTANDING];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               resp_err_q, resp_err_d;
`ifdef RR_ARB_EN
  logic [OWN_W-1:0]   last_grant_q, last_grant_d;
`endif

  logic [OWN_W-1:0]   pick;
  logic [OWN_W-1:0]   sel;
  logic               mem_req_raw;
  logic               accept;
  logic               pop;
  logic [OWN_W-1:0]   head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Winner among simultaneous requests in IDLE.
  always_comb begin
    pick = data_bus.req ? OWN_DATA : OWN_INST;
`ifdef RR_ARB_EN
    if (inst_bus.req && data_bus.req) begin
      pick = (last_grant_q == OWN_DATA) ? OWN_INST : OWN_DATA;
    end
`endif
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    sel         = grant_q;
    mem_req_raw = 1'b0;
    case (state_q)
      IDLE: begin
        if ((count_q < CNT_MAX) && (inst_bus.req || data_bus.req)) begin
          mem_req_raw = 1'b1;
          sel         = pick;
          if (!mem_bus.addr_ok) begin
            state_d = LOCKED;
            grant_d = pick;
          end
        end
      end
      LOCKED: begin
        mem_req_raw = 1'b1;
        if (mem_bus.addr_ok) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_bus.req   = mem_req_raw & ~reset;
  assign mem_bus.wr    = (sel == OWN_DATA) ? data_bus.wr    : inst_bus.wr;
  assign mem_bus.size  = (sel == OWN_DATA) ? data_bus.size  : inst_bus.size;
  assign mem_bus.addr  = (sel == OWN_DATA) ? data_bus.addr  : inst_bus.addr;
  assign mem_bus.wstrb = (sel == OWN_DATA) ? data_bus.wstrb : inst_bus.wstrb;
  assign mem_bus.wdata = (sel == OWN_DATA) ? data_bus.wdata : inst_bus.wdata;

  assign accept = mem_bus.req & mem_bus.addr_ok;
  assign inst_bus.addr_ok = accept & (sel == OWN_INST);
  assign data_bus.addr_ok = accept & (sel == OWN_DATA);

  // A response with no outstanding tag is dropped and flagged instead of popped.
  assign pop  = mem_bus.data_ok & (count_q != '0) & ~reset;
  assign head = own_q[rd_ptr_q];

  assign inst_bus.data_ok = pop & (head == OWN_INST);
  assign data_bus.data_ok = pop & (head == OWN_DATA);
  assign inst_bus.rdata   = inst_bus.data_ok ? mem_bus.rdata : 32'h0;
  assign data_bus.rdata   = data_bus.data_ok ? mem_bus.rdata : 32'h0;
  assign resp_err         = resp_err_q;

  always_comb begin
    own_d      = own_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    resp_err_d = resp_err_q | (mem_bus.data_ok & (count_q == '0));
`ifdef RR_ARB_EN
    last_grant_d = last_grant_q;
`endif
    if (accept) begin
      own_d[wr_ptr_q] = sel;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
`ifdef RR_ARB_EN
      last_grant_d    = sel;
`endif
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (accept && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !accept) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_q    <= OWN_INST;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      resp_err_q <= 1'b0;
      for (int i = 0; i < OUTSTANDING; i++) begin
        own_q[i] <= OWN_INST;
      end
`ifdef RR_ARB_EN
      last_grant_q <= OWN_DATA;
`endif
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      resp_err_q <= resp_err_d;
      own_q      <= own_d;
`ifdef RR_ARB_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Self-checking bench for mem_req_arbiter: directed scenarios plus a randomized run
// against a queue-based reference model of the arbitration and in-order response rules.
module tb_mem_req_arbiter;

  localparam int OUT = 2;
`ifdef RR_ARB_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk;
  logic reset;
  logic resp_err;
  int   n_checks;
  int   n_fail;

  mem_req_arbiter_if inst_bus ();
  mem_req_arbiter_if data_bus ();
  mem_req_arbiter_if mem_bus ();

  mem_req_arbiter #(.OUTSTANDING(OUT), .OWN_W(1)) dut (
    .clk      (clk),
    .reset    (reset),
    .inst_bus (inst_bus),
    .data_bus (data_bus),
    .mem_bus  (mem_bus),
    .resp_err (resp_err)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    inst_bus.req = 0; inst_bus.wr = 0; inst_bus.size = 2'd2; inst_bus.addr = 0;
    inst_bus.wstrb = 4'hf; inst_bus.wdata = 0;
    data_bus.req = 0; data_bus.wr = 0; data_bus.size = 2'd2; data_bus.addr = 0;
    data_bus.wstrb = 4'hf; data_bus.wdata = 0;
    mem_bus.addr_ok = 0; mem_bus.data_ok = 0; mem_bus.rdata = 0;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    #3;
    reset = 0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1;
    inst_bus.req = 1; data_bus.req = 1; mem_bus.addr_ok = 1; mem_bus.data_ok = 1;
    #1;
    n_checks++; if (mem_bus.req !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_mem_req got %b want 0", mem_bus.req); end
    n_checks++; if (inst_bus.addr_ok !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_inst_addr_ok got %b want 0", inst_bus.addr_ok); end
    n_checks++; if (data_bus.addr_ok !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_data_addr_ok got %b want 0", data_bus.addr_ok); end
    n_checks++; if (inst_bus.data_ok !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_inst_data_ok got %b want 0", inst_bus.data_ok); end
    n_checks++; if (data_bus.data_ok !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_data_data_ok got %b want 0", data_bus.data_ok); end
    n_checks++; if (resp_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_resp_err got %b want 0", resp_err); end
    do_reset();
  endtask

  task automatic test_single_inst();
    inst_bus.req = 1; inst_bus.addr = 32'h1000; mem_bus.addr_ok = 1;
    #1;
    n_checks++; if (inst_bus.addr_ok !== 1'b1) begin n_fail++; $display("[TB] FAIL single_inst_addr_ok got %b want 1", inst_bus.addr_ok); end
    n_checks++; if (mem_bus.addr !== 32'h1000) begin n_fail++; $display("[TB] FAIL single_mem_addr got %h want 00001000", mem_bus.addr); end
    n_checks++; if (data_bus.addr_ok !== 1'b0) begin n_fail++; $display("[TB] FAIL single_data_addr_ok got %b want 0", data_bus.addr_ok); end
    tick();
    inst_bus.req = 0; mem_bus.addr_ok = 0;
    #1;
    n_checks++; if (inst_bus.data_ok !== 1'b0) begin n_fail++; $display("[TB] FAIL single_early_data_ok got %b want 0", inst_bus.data_ok); end
    tick();
    mem_bus.data_ok = 1; mem_bus.rdata = 32'h02800000;
    #1;
    n_checks++; if (inst_bus.data_ok !== 1'b1) begin n_fail++; $display("[TB] FAIL single_inst_data_ok got %b want 1", inst_bus.data_ok); end
    n_checks++; if (inst_bus.rdata !== 32'h02800000) begin n_fail++; $display("[TB] FAIL single_inst_rdata got %h want 02800000", inst_bus.rdata); end
    n_checks++; if (data_bus.data_ok !== 1'b0) begin n_fail++; $display("[TB] FAIL single_data_data_ok got %b want 0", data_bus.data_ok); end
    tick();
    idle_inputs();
  endtask

  task automatic test_priority();
    logic [31:0] first_addr, second_addr;
    first_addr  = RR ? 32'hA0 : 32'hD0;
    second_addr = RR ? 32'hD0 : 32'hA0;
    inst_bus.req = 1; inst_bus.addr = 32'hA0;
    data_bus.req = 1; data_bus.addr = 32'hD0; mem_bus.addr_ok = 1;
    #1;
    n_checks++; if (mem_bus.addr !== first_addr) begin n_fail++; $display("[TB] FAIL prio_first_addr got %h want %h", mem_bus.addr, first_addr); end
    n_checks++; if (data_bus.addr_ok !== !RR) begin n_fail++; $display("[TB] FAIL prio_first_data_addr_ok got %b want %b", data_bus.addr_ok, !RR); end
    tick();
    if (RR) inst_bus.req = 0; else data_bus.req = 0;
    #1;
    n_checks++; if (mem_bus.addr !== second_addr) begin n_fail++; $display("[TB] FAIL prio_second_addr got %h want %h", mem_bus.addr, second_addr); end
    n_checks++; if (inst_bus.addr_ok !== !RR) begin n_fail++; $display("[TB] FAIL prio_second_inst_addr_ok got %b want %b", inst_bus.addr_ok, !RR); end
    tick();
    idle_inputs();
    mem_bus.data_ok = 1; mem_bus.rdata = 32'h33;
    #1;
    n_checks++; if (data_bus.data_ok !== !RR) begin n_fail++; $display("[TB] FAIL prio_resp1_data_ok got %b want %b", data_bus.data_ok, !RR); end
    tick();
    mem_bus.rdata = 32'h44;
    #1;
    n_checks++; if (inst_bus.data_ok !== !RR) begin n_fail++; $display("[TB] FAIL prio_resp2_inst_ok got %b want %b", inst_bus.data_ok, !RR); end
    tick();
    idle_inputs();
  endtask

  task automatic test_lock_hold();
    data_bus.req = 1; data_bus.addr = 32'hD4; mem_bus.addr_ok = 0;
    for (int c = 0; c < 4; c++) begin
      if (c == 1) begin inst_bus.req = 1; inst_bus.addr = 32'hA4; end
      if (c == 3) mem_bus.addr_ok = 1;
      #1;
      n_checks++; if (mem_bus.addr !== 32'hD4 || mem_bus.req !== 1'b1) begin n_fail++; $display("[TB] FAIL lock_addr cycle %0d got req=%b addr=%h want req=1 addr=000000d4", c, mem_bus.req, mem_bus.addr); end
      n_checks++; if (data_bus.addr_ok !== (c == 3)) begin n_fail++; $display("[TB] FAIL lock_data_addr_ok cycle %0d got %b want %b", c, data_bus.addr_ok, c == 3); end
      n_checks++; if (inst_bus.addr_ok !== 1'b0) begin n_fail++; $display("[TB] FAIL lock_inst_wait cycle %0d got %b want 0", c, inst_bus.addr_ok); end
      tick();
    end
    data_bus.req = 0;
    #1;
    n_checks++; if (inst_bus.addr_ok !== 1'b1 || mem_bus.addr !== 32'hA4) begin n_fail++; $display("[TB] FAIL lock_inst_after got ok=%b addr=%h want ok=1 addr=000000a4", inst_bus.addr_ok, mem_bus.addr); end
    tick();
    idle_inputs();
    mem_bus.data_ok = 1; mem_bus.rdata = 32'h5;
    tick(); tick();
    idle_inputs();
  endtask

  task automatic test_full();
    inst_bus.req = 1; inst_bus.addr = 32'h100; mem_bus.addr_ok = 1;
    tick();
    inst_bus.req = 0; data_bus.req = 1; data_bus.addr = 32'h200;
    tick();
    data_bus.req = 0; inst_bus.req = 1; inst_bus.addr = 32'h104;
    #1;
    n_checks++; if (mem_bus.req !== 1'b0 || inst_bus.addr_ok !== 1'b0) begin n_fail++; $display("[TB] FAIL full_blocks got req=%b ok=%b want 0 0", mem_bus.req, inst_bus.addr_ok); end
    tick();
    mem_bus.data_ok = 1; mem_bus.rdata = 32'h55;
    #1;
    n_checks++; if (mem_bus.req !== 1'b0) begin n_fail++; $display("[TB] FAIL full_pop_cycle_req got %b want 0", mem_bus.req); end
    n_checks++; if (inst_bus.data_ok !== 1'b1 || inst_bus.rdata !== 32'h55) begin n_fail++; $display("[TB] FAIL full_pop_inst got ok=%b rdata=%h want 1 00000055", inst_bus.data_ok, inst_bus.rdata); end
    tick();
    mem_bus.data_ok = 0;
    #1;
    n_checks++; if (mem_bus.req !== 1'b1 || inst_bus.addr_ok !== 1'b1) begin n_fail++; $display("[TB] FAIL full_resume got req=%b ok=%b want 1 1", mem_bus.req, inst_bus.addr_ok); end
    tick();
    idle_inputs();
    mem_bus.data_ok = 1;
    tick(); tick();
    idle_inputs();
  endtask

  task automatic test_in_order();
    inst_bus.req = 1; inst_bus.addr = 32'h300; mem_bus.addr_ok = 1;
    tick();
    inst_bus.req = 0; data_bus.req = 1; data_bus.addr = 32'h400;
    tick();
    idle_inputs();
    mem_bus.data_ok = 1; mem_bus.rdata = 32'h11;
    #1;
    n_checks++; if (inst_bus.rdata !== 32'h11 || data_bus.data_ok !== 1'b0) begin n_fail++; $display("[TB] FAIL order_first got inst_rdata=%h data_ok=%b want 00000011 0", inst_bus.rdata, data_bus.data_ok); end
    tick();
    mem_bus.rdata = 32'h22;
    #1;
    n_checks++; if (data_bus.rdata !== 32'h22 || inst_bus.rdata !== 32'h0) begin n_fail++; $display("[TB] FAIL order_second got data_rdata=%h inst_rdata=%h want 00000022 00000000", data_bus.rdata, inst_bus.rdata); end
    tick();
    idle_inputs();
  endtask

  task automatic test_resp_err_reset();
    mem_bus.data_ok = 1; mem_bus.rdata = 32'h99;
    #1;
    n_checks++; if (inst_bus.data_ok !== 1'b0 || data_bus.data_ok !== 1'b0) begin n_fail++; $display("[TB] FAIL err_no_data_ok got inst=%b data=%b want 0 0", inst_bus.data_ok, data_bus.data_ok); end
    tick();
    mem_bus.data_ok = 0;
    #1;
    n_checks++; if (resp_err !== 1'b1) begin n_fail++; $display("[TB] FAIL err_sticky got %b want 1", resp_err); end
    data_bus.req = 1; data_bus.addr = 32'h500;
    tick();
    #1;
    n_checks++; if (resp_err !== 1'b1 || mem_bus.req !== 1'b1) begin n_fail++; $display("[TB] FAIL err_held_locked got err=%b req=%b want 1 1", resp_err, mem_bus.req); end
    reset = 1;
    #1;
    n_checks++; if (mem_bus.req !== 1'b0 || resp_err !== 1'b0) begin n_fail++; $display("[TB] FAIL err_reset_locked got req=%b err=%b want 0 0", mem_bus.req, resp_err); end
    do_reset();
  endtask

  task automatic test_random();
    bit          q[$];
    bit          m_lock, m_lock_own, m_last;
    bit          ip, dp, e_req, e_sel, acc, pop, head;
    logic [31:0] ia, iw, da, dw, e_irdata, e_drdata, e_addr, e_wdata;
    do_reset();
    m_lock = 0; m_lock_own = 0; m_last = 1; ip = 0; dp = 0;
    ia = 0; iw = 0; da = 0; dw = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!ip && $urandom_range(1, 0) == 1) begin ip = 1; ia = $urandom; iw = $urandom; end
      if (!dp && $urandom_range(1, 0) == 1) begin dp = 1; da = $urandom; dw = $urandom; end
      inst_bus.req = ip; inst_bus.addr = ia; inst_bus.wdata = iw; inst_bus.wr = 0;
      data_bus.req = dp; data_bus.addr = da; data_bus.wdata = dw; data_bus.wr = 1;
      mem_bus.addr_ok = ($urandom_range(2, 0) != 0);
      mem_bus.data_ok = (q.size() > 0) && ($urandom_range(1, 0) == 1);
      mem_bus.rdata = $urandom;
      #1;
      e_req = 0; e_sel = 0;
      if (m_lock) begin
        e_req = 1; e_sel = m_lock_own;
      end else if (q.size() < OUT && (ip || dp)) begin
        e_req = 1;
        e_sel = (ip && dp) ? (RR ? !m_last : 1'b1) : dp;
      end
      acc = e_req && mem_bus.addr_ok;
      pop = mem_bus.data_ok && q.size() > 0;
      head = pop ? q[0] : 1'b0;
      e_irdata = (pop && !head) ? mem_bus.rdata : 32'h0;
      e_drdata = (pop && head) ? mem_bus.rdata : 32'h0;
      e_addr  = e_sel ? da : ia;
      e_wdata = e_sel ? dw : iw;
      n_checks++; if (mem_bus.req !== e_req) begin n_fail++; $display("[TB] FAIL rnd_mem_req cycle %0d got %b want %b", cyc, mem_bus.req, e_req); end
      if (e_req) begin
        n_checks++; if (mem_bus.addr !== e_addr || mem_bus.wdata !== e_wdata) begin n_fail++; $display("[TB] FAIL rnd_payload cycle %0d got %h/%h want %h/%h", cyc, mem_bus.addr, mem_bus.wdata, e_addr, e_wdata); end
      end
      n_checks++; if (inst_bus.addr_ok !== (acc && !e_sel) || data_bus.addr_ok !== (acc && e_sel)) begin n_fail++; $display("[TB] FAIL rnd_addr_ok cycle %0d got i=%b d=%b want i=%b d=%b", cyc, inst_bus.addr_ok, data_bus.addr_ok, acc && !e_sel, acc && e_sel); end
      n_checks++; if (inst_bus.data_ok !== (pop && !head) || data_bus.data_ok !== (pop && head)) begin n_fail++; $display("[TB] FAIL rnd_data_ok cycle %0d got i=%b d=%b want i=%b d=%b", cyc, inst_bus.data_ok, data_bus.data_ok, pop && !head, pop && head); end
      n_checks++; if (inst_bus.rdata !== e_irdata || data_bus.rdata !== e_drdata) begin n_fail++; $display("[TB] FAIL rnd_rdata cycle %0d got i=%h d=%h want i=%h d=%h", cyc, inst_bus.rdata, data_bus.rdata, e_irdata, e_drdata); end
      n_checks++; if (resp_err !== 1'b0) begin n_fail++; $display("[TB] FAIL rnd_resp_err cycle %0d got %b want 0", cyc, resp_err); end
      if (pop) void'(q.pop_front());
      if (acc) begin
        q.push_back(e_sel);
        m_last = e_sel;
        if (e_sel) dp = 0; else ip = 0;
      end
      m_lock = e_req && !mem_bus.addr_ok;
      m_lock_own = e_sel;
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    clk = 0; reset = 1; n_checks = 0; n_fail = 0;
    idle_inputs();
    tick();
    test_reset();
    test_single_inst();
    test_priority();
    test_lock_hold();
    test_full();
    test_in_order();
    test_resp_err_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
